// File: rtl/mas_mul_pkg.sv
// rtl/mas_mul_pkg.sv - shared defaults, types and index helper for the multiplier arbiter
package mas_mul_pkg;
    localparam int W_DEF     = 16;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = $clog2(N_REQ_DEF);

    typedef logic [ID_W-1:0] id_t;
    typedef struct packed { logic valid; id_t id; } tag_t;
    typedef struct packed { id_t id; logic [2*W_DEF-1:0] res; } rsp_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/mas_mul_rr_arb.sv
// rtl/mas_mul_rr_arb.sv - round-robin picker: first set request at or after ptr, wrapping
module mas_mul_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % N_REQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
                idx = IDW'((int'(ptr) + i) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/mas_mul_arbiter.sv
// rtl/mas_mul_arbiter.sv - shares one fixed-latency multiplier among N_REQ clients; MAS_MUL_ARB_STATS_EN adds grant/stall counters
module mas_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int W          = 16,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [W-1:0]             mul_in1,
    output logic [W-1:0]             mul_in2,
    input  logic [2*W-1:0]           mul_res,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [2*W-1:0]           rsp_res
`ifdef MAS_MUL_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]      stat_grants,
    output logic [15:0]              stat_stall
`endif
);
    import mas_mul_pkg::*;

    localparam int IDW  = $clog2(N_REQ);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OCCW = $clog2(FIFO_DEPTH + MUL_LAT + 2);

    logic [IDW-1:0]   rr_ptr;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gidx;
    logic             gany;
    logic             credit_ok;
    logic             hs;

    mas_mul_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_rr_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    // Tag pipe covers the mul_in register plus MUL_LAT multiplier stages.
    logic [MUL_LAT:0] tag_v;
    logic [IDW-1:0]   tag_id [MUL_LAT+1];

    logic [IDW-1:0]   fifo_id  [FIFO_DEPTH];
    logic [2*W-1:0]   fifo_res [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;
    logic             push, pop;
    logic [OCCW-1:0]  inflight, occ;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MUL_LAT; i++) inflight = inflight + OCCW'(tag_v[i]);
    end

    // Every issued op owns a FIFO slot from issue until pop, so the FIFO cannot overflow.
    assign occ       = inflight + OCCW'(fifo_cnt);
    assign credit_ok = occ < OCCW'(FIFO_DEPTH);
    assign req_ready = (rst || !credit_ok) ? '0 : gnt;
    assign hs        = gany && credit_ok && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            mul_in1 <= '0;
            mul_in2 <= '0;
            tag_v   <= '0;
        end else begin
            tag_v[0] <= hs;
            if (hs) begin
                rr_ptr  <= IDW'(next_idx(int'(gidx), N_REQ));
                mul_in1 <= req_a[int'(gidx)*W +: W];
                mul_in2 <= req_b[int'(gidx)*W +: W];
            end
            for (int i = 1; i <= MUL_LAT; i++) tag_v[i] <= tag_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= gidx;
        for (int i = 1; i <= MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
    end

    assign push      = tag_v[MUL_LAT];
    assign rsp_valid = fifo_cnt != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]  : '0;
    assign rsp_res   = rsp_valid ? fifo_res[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= tag_id[MUL_LAT];
            fifo_res[wr_ptr] <= mul_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef MAS_MUL_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && stat_grants[i*16 +: 16] != 16'hFFFF)
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
            end
            if ((|req_valid) && !credit_ok && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mas_mul_arbiter.sv
// tb/tb_mas_mul_arbiter.sv - scoreboard bench with a behavioural arbiter/credit model and multiplier model
module tb_mas_mul_arbiter;
    import mas_mul_pkg::*;

    localparam int N = 4, W = 16, LAT = 4, DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0, req_b = '0;
    logic [W-1:0]    mul_in1, mul_in2;
    logic [2*W-1:0]  mul_res;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [2*W-1:0]  rsp_res;
`ifdef MAS_MUL_ARB_STATS_EN
    logic [N*16-1:0] stat_grants;
    logic [15:0]     stat_stall;
`endif

    mas_mul_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_res(mul_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res)
`ifdef MAS_MUL_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: product of the operands seen LAT cycles earlier.
    logic [2*W-1:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= (2*W)'(mul_in1) * (2*W)'(mul_in2);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_res = mp[LAT-1];

    int   total = 0, bad = 0;
    int   pushes = 0, pops = 0, stall_cnt = 0, mptr = 0;
    rsp_t exp_q [$];

    // Issue side: credit = ops issued minus ops popped; grant is first valid at/after pointer.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic         found;
        exp_rdy = '0;
        found   = 1'b0;
        if (rst) begin
            pushes = 0; mptr = 0; stall_cnt = 0;
        end else begin
            if (pushes - pops < DEPTH) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && req_valid[(mptr + i) % N]) begin
                        found = 1'b1;
                        exp_rdy[(mptr + i) % N] = 1'b1;
                    end
                end
            end else if (|req_valid) begin
                stall_cnt++;
            end
        end
        total++;
        if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
        end
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    rsp_t e;
                    e.id  = 2'(i);
                    e.res = (2*W)'(req_a[i*W +: W]) * (2*W)'(req_b[i*W +: W]);
                    exp_q.push_back(e);
                    pushes++;
                    mptr = (i + 1) % N;
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            exp_q.delete();
            pops = 0;
        end else if (rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp t=%0t got id=%0d res=%h exp=none", $time, rsp_id, rsp_res);
            end else if (rsp_id !== exp_q[0].id || rsp_res !== exp_q[0].res) begin
                bad++;
                $display("FAIL rsp t=%0t got id=%0d res=%h exp id=%0d res=%h",
                         $time, rsp_id, rsp_res, exp_q[0].id, exp_q[0].res);
            end
            if (rsp_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pops++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 16'($urandom);
            req_b[i*W +: W] = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0; rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin cyc(); n++; end
        check("drain_empty", longint'(exp_q.size()), 0);
    endtask

    task automatic single(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a; req_b[id*W +: W] = b;
        req_valid = '0; req_valid[id] = 1'b1;
        cyc();
        req_valid = '0;
    endtask

    initial begin
        int lat, p0;
        bit found;
        rst = 1'b1;
        cyc(); cyc(); #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_res", rsp_res, 0);
        check("rst_mul_in1", mul_in1, 0);
        check("rst_mul_in2", mul_in2, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        cyc();

        // Single op latency
        single(0, 16'd5, 16'd7);
        lat = 0; found = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (!found && rsp_valid) begin found = 1; lat = k; end
            cyc();
        end
        check("single_latency", lat, 6);
        drain();

        // Fairness with all requesters valid
        req_valid = '1;
        for (int k = 0; k < 24; k++) begin rand_ops(); cyc(); end
        drain();

        // Extremes
        single(2, 16'h7FFF, 16'h7FFF);
        single(3, 16'h0000, 16'hFFFF);
        single(1, 16'hFFFF, 16'hFFFF);
        drain();

        // Backpressure: only credit-limited issue
        do_reset();
        p0 = pushes;
        rsp_ready = 1'b0; req_valid = 4'b0010;
        for (int k = 0; k < 20; k++) begin rand_ops(); cyc(); end
        #1;
        check("bp_handshakes", pushes - p0, 8);
        check("bp_ready_low", req_ready, 0);
`ifdef MAS_MUL_ARB_STATS_EN
        check("stat_grants1", stat_grants[16 +: 16], 8);
        check("stat_stall", stat_stall, stall_cnt);
`endif
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin rand_ops(); cyc(); end
        check("bp_resume", (pushes - p0) > 8, 1);
        drain();

        // Reset with ops in flight
        req_valid = '1;
        for (int k = 0; k < 3; k++) begin rand_ops(); cyc(); end
        req_valid = '0; rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_req_ready", req_ready, 0);
        for (int k = 0; k < 15; k++) cyc();
        drain();

        // Random traffic with random backpressure
        for (int k = 0; k < 800; k++) begin
            rand_ops();
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
